// File: rtl/thumb_fetch_if.sv
// thumb_fetch_if: memory, decoder and redirect signals of the fetch stage.
// master is the fetch unit, slave is memory plus decode/execute.
interface thumb_fetch_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_rdata;
  logic              instr_valid;
  logic [15:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  modport master (
    output mem_req, mem_addr,
    output instr_valid, instr, instr_pc,
    input  mem_valid, mem_rdata,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    input  instr_valid, instr, instr_pc,
    output mem_valid, mem_rdata,
    output instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/thumb_fetch.sv
// thumb_fetch: 32-bit word fetch split into Thumb halfwords,
// buffered in a 4-entry FIFO, flushed by execute-stage redirects.
module thumb_fetch #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clock,
  input logic           nreset,
  thumb_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic        skip_lo;
  logic [15:0] q_instr [4];
  logic [31:0] q_pc [4];
  logic [1:0]  rd, wr;
  logic [2:0]  count, count_nxt;
  logic [1:0]  npush;
  logic        pop, take, issue;
  logic [31:0] word_pc;
  logic        unused;

  assign bus.instr_valid = count != 3'd0;
  assign bus.instr       = q_instr[rd];
  assign bus.instr_pc    = q_pc[rd];
  assign pop     = bus.instr_valid && bus.instr_ready;
  assign word_pc = fetch_pc - 32'd4;
  assign unused  = bus.redirect_pc[0];

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    issue     = 1'b0;
    npush     = 2'd0;
    unique case (state)
      IDLE: begin
        if (!bus.redirect_valid && count <= 3'd2) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          state_nxt = bus.mem_valid ? IDLE : DROP;
        end else if (bus.mem_valid) begin
          take      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (bus.mem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (take) npush = skip_lo ? 2'd1 : 2'd2;
    count_nxt = count - {2'b00, pop} + {1'b0, npush};
    // chain the next request off the response edge for full throughput
    if (take && count_nxt <= 3'd2) begin
      issue     = 1'b1;
      state_nxt = WAIT;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      fetch_pc     <= {RESET_PC[31:2], 2'b00};
      skip_lo      <= RESET_PC[1];
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= RESET_PC[ADDR_W+1:2];
      rd           <= 2'd0;
      wr           <= 2'd0;
      count        <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state       <= state_nxt;
      bus.mem_req <= issue;
      if (issue) begin
        bus.mem_addr <= fetch_pc[ADDR_W+1:2];
        fetch_pc     <= fetch_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        skip_lo  <= bus.redirect_pc[1];
        rd       <= 2'd0;
        wr       <= 2'd0;
        count    <= 3'd0;
      end else begin
        if (take) begin
          skip_lo <= 1'b0;
          if (skip_lo) begin
            q_instr[wr] <= bus.mem_rdata[31:16];
            q_pc[wr]    <= word_pc + 32'd2;
          end else begin
            q_instr[wr]       <= bus.mem_rdata[15:0];
            q_pc[wr]          <= word_pc;
            q_instr[wr+2'd1]  <= bus.mem_rdata[31:16];
            q_pc[wr+2'd1]     <= word_pc + 32'd2;
          end
        end
        rd    <= rd + {1'b0, pop};
        wr    <= wr + npush;
        count <= count_nxt;
      end
    end
  end
endmodule

// File: tb/tb_thumb_fetch.sv
// tb_thumb_fetch: directed tests with an instruction-stream model
// that predicts every presented halfword from memory contents.
module tb_thumb_fetch;
  localparam int AW = 10;

  logic clock = 1'b0;
  logic nreset = 1'b1;
  always #5 clock = ~clock;

  thumb_fetch_if #(.ADDR_W(AW)) bus ();

  thumb_fetch #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  logic [31:0] mem [1024];
  int tests = 0;
  int fails = 0;
  int cyc;
  int lat = 1;
  bit inject = 0;

  logic [31:0] acc_pc [$];
  logic [15:0] acc_in [$];
  logic [AW-1:0] req_addr [$];
  int req_n;
  int first_valid;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[AW+1:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  always @(posedge clock or negedge nreset)
    if (!nreset) cyc <= 0;
    else cyc <= cyc + 1;

  // memory: answers each request lat cycles later
  initial begin : responder
    int pend;
    logic [AW-1:0] paddr;
    pend = 0;
    paddr = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      bus.mem_valid = 1'b0;
      if (!nreset) begin
        pend = 0;
      end else if (inject && cyc == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = mem[paddr];
          end
        end
        if (bus.mem_req) begin
          paddr = bus.mem_addr;
          pend = lat;
        end
      end
    end
  end

  // model: head must always be the next halfword of the program order
  initial begin : model
    logic [31:0] exp_pc;
    bit redir_prev;
    exp_pc = 0;
    redir_prev = 0;
    forever begin
      @(negedge clock);
      if (!nreset) begin
        exp_pc = 32'h0;
        redir_prev = 0;
        first_valid = -1;
        req_n = 0;
        acc_pc.delete();
        acc_in.delete();
        req_addr.delete();
      end else begin
        if (redir_prev) chk("flush", {31'b0, bus.instr_valid}, 0);
        if (bus.instr_valid) begin
          chk("head_pc", bus.instr_pc, exp_pc);
          chk("head_instr", {16'b0, bus.instr}, {16'b0, hw(exp_pc)});
          if (first_valid < 0) first_valid = cyc;
        end
        if (bus.mem_req) begin
          req_n++;
          req_addr.push_back(bus.mem_addr);
        end
        if (bus.instr_valid && bus.instr_ready) begin
          acc_pc.push_back(bus.instr_pc);
          acc_in.push_back(bus.instr);
          exp_pc = exp_pc + 32'd2;
        end
        if (bus.redirect_valid) begin
          exp_pc = {bus.redirect_pc[31:1], 1'b0};
          acc_pc.delete();
          acc_in.delete();
          req_addr.delete();
        end
        redir_prev = bus.redirect_valid;
      end
    end
  end

  task automatic do_reset(input bit rdy, input int l);
    nreset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = rdy;
    lat = l;
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (bus.mem_req) return;
    end
    chk("wait_req_timeout", 0, 1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = {16'h4000 + 16'(2 * i + 1), 16'h4000 + 16'(2 * i)};
    mem[0] = 32'h2205_2103;
    mem[1] = 32'h4770_1889;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    #1 nreset = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("rst_mem_addr", {22'b0, bus.mem_addr}, 0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 0);
    chk("rst_instr", {16'b0, bus.instr}, 0);
    chk("rst_pc", bus.instr_pc, 0);

    // basic stream, zero-wait memory
    do_reset(1'b1, 1);
    run_to(21);
    chk("first_valid_cyc", first_valid, 3);
    chk("sustained_cnt", acc_pc.size(), 18);
    chk("seq0_pc", acc_pc[0], 32'h0);
    chk("seq0_in", {16'b0, acc_in[0]}, 32'h2103);
    chk("seq1_in", {16'b0, acc_in[1]}, 32'h2205);
    chk("seq2_in", {16'b0, acc_in[2]}, 32'h1889);
    chk("seq3_pc", acc_pc[3], 32'h6);
    chk("seq3_in", {16'b0, acc_in[3]}, 32'h4770);

    // stall: FIFO fills with two words, then no more requests
    do_reset(1'b0, 1);
    run_to(11);
    chk("stall_reqs", req_n, 2);
    chk("stall_valid", {31'b0, bus.instr_valid}, 1);
    bus.instr_ready = 1'b1;
    step(20);
    chk("drain_pc1", acc_pc[1], 32'h2);
    chk("drain_pc3", acc_pc[3], 32'h6);
    chk("drain_in3", {16'b0, acc_in[3]}, 32'h4770);

    // redirect with outstanding request, 3-cycle memory
    do_reset(1'b1, 3);
    wait_req();
    step(1);
    redirect(32'h12);
    step(20);
    chk("rd12_pc0", acc_pc[0], 32'h12);
    chk("rd12_in0", {16'b0, acc_in[0]}, 32'h4009);
    chk("rd12_pc1", acc_pc[1], 32'h14);
    chk("rd12_in1", {16'b0, acc_in[1]}, 32'h400A);

    // redirect coinciding with response and a popped head
    do_reset(1'b1, 1);
    run_to(8);
    wait_req();
    step(1);
    chk("rdv_head_valid", {31'b0, bus.instr_valid}, 1);
    redirect(32'h40);
    step(10);
    chk("rdv_pc0", acc_pc[0], 32'h40);
    chk("rdv_in0", {16'b0, acc_in[0]}, 32'h4020);

    // address wrap at the top of instruction memory
    do_reset(1'b1, 1);
    run_to(5);
    redirect(32'hFFC);
    step(14);
    chk("wrap_addr0", {22'b0, req_addr[0]}, 32'd1023);
    chk("wrap_addr1", {22'b0, req_addr[1]}, 32'd0);
    chk("wrap_pc0", acc_pc[0], 32'hFFC);
    chk("wrap_in0", {16'b0, acc_in[0]}, 32'h47FE);
    chk("wrap_pc1", acc_pc[1], 32'hFFE);
    chk("wrap_pc2", acc_pc[2], 32'h1000);
    chk("wrap_in2", {16'b0, acc_in[2]}, 32'h2103);
    chk("wrap_pc3", acc_pc[3], 32'h1002);

    // reset mid-request, stale response after release
    do_reset(1'b1, 3);
    run_to(9);
    wait_req();
    #2 nreset = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("arst_valid", {31'b0, bus.instr_valid}, 0);
    chk("arst_pc", bus.instr_pc, 0);
    chk("arst_instr", {16'b0, bus.instr}, 0);
    chk("arst_addr", {22'b0, bus.mem_addr}, 0);
    inject = 1'b1;
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
    step(20);
    inject = 1'b0;
    chk("arst_req0", {22'b0, req_addr[0]}, 0);
    chk("arst_pc0", acc_pc[0], 32'h0);
    chk("arst_in0", {16'b0, acc_in[0]}, 32'h2103);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
